// File: rtl/redmule_cfg_arbiter.sv
// redmule_cfg_arbiter
// Shares the single RedMulE control-slave port between NumReq masters.
// Grants are round-robin per transaction. A write into the job-config region
// locks the port to its issuer until that owner writes the trigger register,
// or stays idle for LockTimeout cycles. In-order responses are routed back to
// the issuing master through a small index FIFO.
//
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (sync soft clear)
//   req_i/wen_i/be_i/add_i/data_i/id_i  per-master request fields, flattened
//                                       with master k at slice k
//   gnt_o, r_valid_o                     per-master grant / response valid
//   r_data_o                             response data, broadcast
//   slv_*                                request/response to the control slave
//   lock_owner_o, locked_o               lock status
//   lock_err_o                           one-cycle pulse on timeout release
module redmule_cfg_arbiter #(
  parameter int unsigned          NumReq      = 2,
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          IdWidth     = 8,
  parameter logic [AddrWidth-1:0] CfgBase     = 'h40,
  parameter logic [AddrWidth-1:0] TriggerAddr = 'h0,
  parameter int unsigned          LockTimeout = 64,
  parameter int unsigned          MaxOutst    = 2,
  localparam int unsigned         BeWidth     = DataWidth / 8,
  localparam int unsigned         IdxWidth    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic [NumReq-1:0]              req_i,
  input  logic [NumReq-1:0]              wen_i,
  input  logic [NumReq*BeWidth-1:0]      be_i,
  input  logic [NumReq*AddrWidth-1:0]    add_i,
  input  logic [NumReq*DataWidth-1:0]    data_i,
  input  logic [NumReq*IdWidth-1:0]      id_i,
  output logic [NumReq-1:0]              gnt_o,
  output logic [NumReq-1:0]              r_valid_o,
  output logic [DataWidth-1:0]           r_data_o,
  output logic                           slv_req_o,
  output logic                           slv_wen_o,
  output logic [BeWidth-1:0]             slv_be_o,
  output logic [AddrWidth-1:0]           slv_add_o,
  output logic [DataWidth-1:0]           slv_data_o,
  output logic [IdWidth-1:0]             slv_id_o,
  input  logic                           slv_gnt_i,
  input  logic                           slv_r_valid_i,
  input  logic [DataWidth-1:0]           slv_r_data_i,
  output logic [IdxWidth-1:0]            lock_owner_o,
  output logic                           locked_o,
  output logic                           lock_err_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutst + 1);
  localparam int unsigned PtrWidth = (MaxOutst > 1) ? $clog2(MaxOutst) : 1;
  localparam int unsigned ToWidth  = (LockTimeout > 1) ? $clog2(LockTimeout) : 1;

  typedef enum logic {StUnlocked, StLocked} state_e;

  state_e                state_q, state_d;
  logic [IdxWidth-1:0]   owner_q, owner_d;
  logic [IdxWidth-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ToWidth-1:0]    to_cnt_q, to_cnt_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [IdxWidth-1:0]   fifo_q [MaxOutst];

  logic                  win_found;
  logic [IdxWidth-1:0]   win_idx;
  logic                  win_wen;
  logic [BeWidth-1:0]    win_be;
  logic [AddrWidth-1:0]  win_add;
  logic [DataWidth-1:0]  win_data;
  logic [IdWidth-1:0]    win_id;

  logic kill, room, hs, pop, owner_req, cfg_wr, trig_wr, timeout;

  // (base + off) mod NumReq
  function automatic logic [IdxWidth-1:0] rr_idx(input logic [IdxWidth-1:0] base,
                                                 input int unsigned         off);
    int unsigned s;
    s = (32'(base) + off) % NumReq;
    return IdxWidth'(s);
  endfunction

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutst - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reset and clear both force every request-side output low immediately.
  assign kill      = rst_i | clear_i;
  assign room      = (cnt_q != CntWidth'(MaxOutst));
  assign owner_req = req_i[owner_q];

  // Winner selection: owner only while locked, else first request from rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    if (state_q == StLocked) begin
      win_found = owner_req;
      win_idx   = owner_q;
    end else begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        if (!win_found && req_i[rr_idx(rr_ptr_q, k)]) begin
          win_found = 1'b1;
          win_idx   = rr_idx(rr_ptr_q, k);
        end
      end
    end
  end

  // Field mux for the winning master.
  always_comb begin
    win_wen  = 1'b0;
    win_be   = '0;
    win_add  = '0;
    win_data = '0;
    win_id   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (win_idx == IdxWidth'(k)) begin
        win_wen  = wen_i[k];
        win_be   = be_i[k*BeWidth +: BeWidth];
        win_add  = add_i[k*AddrWidth +: AddrWidth];
        win_data = data_i[k*DataWidth +: DataWidth];
        win_id   = id_i[k*IdWidth +: IdWidth];
      end
    end
  end

  assign slv_req_o  = win_found & room & ~kill;
  assign hs         = slv_req_o & slv_gnt_i;
  assign slv_wen_o  = slv_req_o ? win_wen  : 1'b0;
  assign slv_be_o   = slv_req_o ? win_be   : '0;
  assign slv_add_o  = slv_req_o ? win_add  : '0;
  assign slv_data_o = slv_req_o ? win_data : '0;
  assign slv_id_o   = slv_req_o ? win_id   : '0;

  always_comb begin
    gnt_o = '0;
    if (slv_req_o) gnt_o[win_idx] = slv_gnt_i;
  end

  // Trigger writes never lock, even if TriggerAddr sits inside the config region.
  assign cfg_wr  = ~win_wen & (win_add >= CfgBase) & (win_add != TriggerAddr);
  assign trig_wr = ~win_wen & (win_add == TriggerAddr);
  assign timeout = (state_q == StLocked) & ~owner_req &
                   (to_cnt_q == ToWidth'(LockTimeout - 1));

  assign lock_err_o   = timeout & ~kill;
  assign locked_o     = (state_q == StLocked);
  assign lock_owner_o = owner_q;

  // Response routing; a response with no pending index is dropped.
  assign pop      = slv_r_valid_i & (cnt_q != '0) & ~kill;
  assign r_data_o = slv_r_data_i;

  always_comb begin
    r_valid_o = '0;
    if (pop) r_valid_o[fifo_q[rd_ptr_q]] = 1'b1;
  end

  // Lock FSM, round-robin pointer and idle timeout.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      StUnlocked: begin
        if (hs) begin
          rr_ptr_d = rr_idx(win_idx, 1);
          if (cfg_wr) begin
            state_d  = StLocked;
            owner_d  = win_idx;
            to_cnt_d = '0;
          end
        end
      end
      StLocked: begin
        if ((hs && trig_wr) || timeout) begin
          state_d  = StUnlocked;
          rr_ptr_d = rr_idx(owner_q, 1);
          owner_d  = '0;
          to_cnt_d = '0;
        end else if (owner_req) begin
          to_cnt_d = '0;
        end else if (to_cnt_q != ToWidth'(LockTimeout - 1)) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = StUnlocked;
    endcase
    if (clear_i) begin
      state_d  = StUnlocked;
      owner_d  = '0;
      rr_ptr_d = '0;
      to_cnt_d = '0;
    end
  end

  // Index FIFO pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (hs)  wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (hs && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!hs && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StUnlocked;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      to_cnt_q <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      to_cnt_q <= to_cnt_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < MaxOutst; k++) fifo_q[k] <= '0;
    end else if (hs) begin
      fifo_q[wr_ptr_q] <= win_idx;
    end
  end

endmodule

// File: tb/tb_redmule_cfg_arbiter.sv
module tb_redmule_cfg_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i, clear_i;
  logic [1:0]  req_i, wen_i;
  logic [7:0]  be_i;
  logic [63:0] add_i, data_i;
  logic [15:0] id_i;
  logic [1:0]  gnt_o, r_valid_o;
  logic [31:0] r_data_o;
  logic        slv_req_o, slv_wen_o;
  logic [3:0]  slv_be_o;
  logic [31:0] slv_add_o, slv_data_o;
  logic [7:0]  slv_id_o;
  logic        slv_gnt_i, slv_r_valid_i;
  logic [31:0] slv_r_data_i;
  logic [0:0]  lock_owner_o;
  logic        locked_o, lock_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  redmule_cfg_arbiter dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .req_i         (req_i),
    .wen_i         (wen_i),
    .be_i          (be_i),
    .add_i         (add_i),
    .data_i        (data_i),
    .id_i          (id_i),
    .gnt_o         (gnt_o),
    .r_valid_o     (r_valid_o),
    .r_data_o      (r_data_o),
    .slv_req_o     (slv_req_o),
    .slv_wen_o     (slv_wen_o),
    .slv_be_o      (slv_be_o),
    .slv_add_o     (slv_add_o),
    .slv_data_o    (slv_data_o),
    .slv_id_o      (slv_id_o),
    .slv_gnt_i     (slv_gnt_i),
    .slv_r_valid_i (slv_r_valid_i),
    .slv_r_data_i  (slv_r_data_i),
    .lock_owner_o  (lock_owner_o),
    .locked_o      (locked_o),
    .lock_err_o    (lock_err_o)
  );

  typedef struct {
    logic [1:0]  req;
    logic        sgnt;
    logic        srv;
    logic [1:0]  gnt;
    logic        sreq;
    logic [1:0]  rv;
    logic [31:0] sadd;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_m(input int m, input logic req, input logic wen, input logic [31:0] add);
    req_i[m]             = req;
    wen_i[m]             = wen;
    add_i[m*32 +: 32]    = add;
    data_i[m*32 +: 32]   = add ^ 32'hA5A5_0000;
    id_i[m*8 +: 8]       = 8'(m + 1);
  endtask

  task automatic idle_inputs();
    req_i = '0; wen_i = '1; be_i = '1; add_i = '0; data_i = '0; id_i = '0;
    clear_i = 1'b0; slv_gnt_i = 1'b0; slv_r_valid_i = 1'b0; slv_r_data_i = '0;
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    idle_inputs();
    rst_i = 1'b1;
    #3;
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 2'b00, 32'h0};
    vecs[1]  = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 2'b01, 32'h8};
    vecs[2]  = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 2'b10, 32'h0};
    vecs[3]  = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 2'b01, 32'h8};
    vecs[4]  = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 2'b10, 32'h0};
    vecs[5]  = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 32'h0};
    vecs[6]  = '{2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 2'b00, 32'h0};
    vecs[7]  = '{2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 2'b00, 32'h8};
    vecs[8]  = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    vecs[9]  = '{2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 32'h0};
    vecs[10] = '{2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 2'b00, 32'h0};
    vecs[11] = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    vecs[12] = '{2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 2'b10, 32'h0};
    vecs[13] = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 32'h0};
    vecs[14] = '{2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 32'h8};
    vecs[15] = '{2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 2'b00, 32'h8};
    vecs[16] = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 2'b10, 32'h0};

    idle_inputs();
    rst_i = 1'b1;
    #12;
    rst_i = 1'b0;
    #1;
    check("reset locked", locked_o, 0);
    check("reset gnt", gnt_o, 0);
    check("reset slv_req", slv_req_o, 0);
    check("reset r_valid", r_valid_o, 0);
    check("reset lock_err", lock_err_o, 0);
    check("reset owner", lock_owner_o, 0);

    // Round-robin reads, response routing, outstanding limit, slave back-pressure.
    for (int i = 0; i < 17; i++) begin
      cyc();
      req_i = vecs[i].req; wen_i = 2'b11; add_i = {32'h8, 32'h0};
      slv_gnt_i = vecs[i].sgnt; slv_r_valid_i = vecs[i].srv;
      slv_r_data_i = 32'(i) * 32'h1111;
      #2;
      check($sformatf("vec%0d gnt", i), gnt_o, vecs[i].gnt);
      check($sformatf("vec%0d slv_req", i), slv_req_o, vecs[i].sreq);
      check($sformatf("vec%0d r_valid", i), r_valid_o, vecs[i].rv);
      check($sformatf("vec%0d locked", i), locked_o, 0);
      check($sformatf("vec%0d r_data", i), r_data_o, 32'(i) * 32'h1111);
      if (vecs[i].sreq) check($sformatf("vec%0d slv_add", i), slv_add_o, vecs[i].sadd);
    end

    // M0 config burst + trigger while M1 requests; one owner-idle cycle mid-lock.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      cyc();
      slv_gnt_i = 1'b1; slv_r_valid_i = 1'b1;
      set_m(1, 1'b1, 1'b1, 32'h0);
      if (c == 3 || c == 8) set_m(0, 1'b0, 1'b0, 32'h0);
      else if (c < 3)       set_m(0, 1'b1, 1'b0, 32'h40 + 32'(c) * 4);
      else if (c < 7)       set_m(0, 1'b1, 1'b0, 32'h40 + 32'(c - 1) * 4);
      else                  set_m(0, 1'b1, 1'b0, 32'h0);
      #2;
      if (c == 8) begin
        check("burst release gnt", gnt_o, 2'b10);
        check("burst release locked", locked_o, 0);
      end else begin
        check($sformatf("burst c%0d gnt", c), gnt_o, (c == 3) ? 2'b00 : 2'b01);
        check($sformatf("burst c%0d locked", c), locked_o, (c != 0));
      end
      if (c == 1) begin
        check("burst slv_data", slv_data_o, 32'hA5A5_0044);
        check("burst slv_id", slv_id_o, 8'h1);
        check("burst owner", lock_owner_o, 0);
      end
    end

    // M1 locks, then idles until the timeout releases it; M0 waits.
    do_reset();
    cyc();
    slv_gnt_i = 1'b1;
    set_m(1, 1'b1, 1'b0, 32'h44);
    set_m(0, 1'b0, 1'b1, 32'h0);
    #2;
    check("to lock gnt", gnt_o, 2'b10);
    for (int k = 1; k <= 65; k++) begin
      cyc();
      slv_r_valid_i = 1'b1;
      set_m(1, 1'b0, 1'b1, 32'h0);
      set_m(0, 1'b1, 1'b1, 32'h0);
      #2;
      if (k == 1) begin
        check("to owner", lock_owner_o, 1);
        check("to r_valid", r_valid_o, 2'b10);
      end
      if (k <= 64) begin
        check($sformatf("to k%0d lock_err", k), lock_err_o, (k == 64));
        check($sformatf("to k%0d gnt", k), gnt_o, 2'b00);
        check($sformatf("to k%0d locked", k), locked_o, 1);
      end else begin
        check("to after lock_err", lock_err_o, 0);
        check("to after locked", locked_o, 0);
        check("to after gnt", gnt_o, 2'b01);
      end
    end

    // Async reset mid-lock with one response outstanding.
    do_reset();
    cyc();
    slv_gnt_i = 1'b1;
    set_m(0, 1'b1, 1'b0, 32'h40);
    #2;
    check("rst lock gnt", gnt_o, 2'b01);
    cyc();
    slv_gnt_i = 1'b0;
    set_m(0, 1'b1, 1'b0, 32'h48);
    #2;
    check("rst pre locked", locked_o, 1);
    check("rst pre slv_req", slv_req_o, 1);
    #1;
    rst_i = 1'b1;
    slv_r_valid_i = 1'b1;
    #1;
    check("rst async locked", locked_o, 0);
    check("rst async slv_req", slv_req_o, 0);
    check("rst async gnt", gnt_o, 0);
    check("rst async r_valid", r_valid_o, 0);
    check("rst async owner", lock_owner_o, 0);
    cyc();
    rst_i = 1'b0;
    req_i = '0;
    slv_r_valid_i = 1'b1;
    #2;
    check("rst stray r_valid", r_valid_o, 0);

    // clear_i during a lock with one response outstanding.
    do_reset();
    cyc();
    slv_gnt_i = 1'b1;
    set_m(0, 1'b1, 1'b0, 32'h48);
    #2;
    check("clr lock gnt", gnt_o, 2'b01);
    cyc();
    clear_i = 1'b1;
    set_m(0, 1'b1, 1'b0, 32'h4C);
    #2;
    check("clr cycle gnt", gnt_o, 0);
    check("clr cycle slv_req", slv_req_o, 0);
    cyc();
    clear_i = 1'b0;
    slv_r_valid_i = 1'b1;
    set_m(0, 1'b1, 1'b1, 32'h0);
    set_m(1, 1'b1, 1'b1, 32'h0);
    #2;
    check("clr after locked", locked_o, 0);
    check("clr after gnt", gnt_o, 2'b01);
    check("clr after r_valid", r_valid_o, 0);
    cyc();
    slv_r_valid_i = 1'b0;
    #2;
    check("clr rr gnt", gnt_o, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/redmule_cfg_arbiter.md
Name: redmule_cfg_arbiter

Overview:
- Shares the single RedMulE control-slave port between NumReq masters, e.g. the XIF instruction decoder's config FSM and the peripheral-bus config path.
- Arbitrates round-robin per transaction.
- Locks the port to one owner for a complete configuration sequence: register writes followed by the trigger write.
- Routes in-order read/write responses back to the issuing master.

Parameters:
NumReq, 2, number of requesting masters
AddrWidth, 32, address width
DataWidth, 32, data width
IdWidth, 8, transaction id width
CfgBase, 'h40, lowest address of the lockable job-config register region
TriggerAddr, 'h0, trigger register address; a granted write here ends a lock
LockTimeout, 64, idle owner cycles before a forced lock release
MaxOutst, 2, maximum outstanding transactions awaiting r_valid

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
clear_i  in  1  synchronous soft clear
req_i  in  NumReq  per-master request
wen_i  in  NumReq  per-master write enable, 0=write, 1=read
be_i  in  NumReq x DataWidth/8  byte enables
add_i  in  NumReq x AddrWidth  addresses
data_i  in  NumReq x DataWidth  write data
id_i  in  NumReq x IdWidth  ids
gnt_o  out  NumReq  per-master grant
r_valid_o  out  NumReq  per-master response valid
r_data_o  out  DataWidth  response data, broadcast to all masters
slv_req_o / slv_wen_o / slv_be_o / slv_add_o / slv_data_o / slv_id_o  out  as above  to control slave
slv_gnt_i  in  1  slave grant
slv_r_valid_i  in  1  slave response valid, in order
slv_r_data_i  in  DataWidth  slave response data
lock_owner_o  out  $clog2(NumReq)  current lock owner, valid when locked_o=1
locked_o  out  1  port locked
lock_err_o  out  1  one-cycle pulse on timeout release

Behaviour:
- Reset (rst_i) or clear_i: all outputs 0, rr_ptr=0, state Unlocked, index FIFO empty, timeout counter 0.
- Arbitration is combinational, zero latency.
  - Unlocked: winner is the first asserted req_i scanning from rr_ptr upward, modulo NumReq.
  - Locked: only the owner is eligible; other masters get gnt_o=0.
  - The winner's fields drive slv_*; gnt_o[winner]=slv_gnt_i; all other gnt_o are 0.
- Outstanding limit: if the FIFO count equals MaxOutst (registered count), slv_req_o=0 and all gnt_o=0. This holds even if slv_r_valid_i is high the same cycle.
- Handshake = slv_req_o & slv_gnt_i. On a handshake:
  - push the winner index into the FIFO;
  - if Unlocked, rr_ptr <= winner+1 (mod NumReq).
- Masters hold req and fields stable until granted. The arbiter never retracts slv_req_o before gnt, except on lock release or clear.
- FSM Unlocked -> Locked: handshake with wen=0 and add >= CfgBase. Owner is the winner; timeout counter is zeroed.
- FSM Locked -> Unlocked, whichever occurs first:
  - (a) owner handshake with wen=0 and add==TriggerAddr: release takes effect the next cycle, rr_ptr <= owner+1;
  - (b) timeout counter reaches LockTimeout-1 while owner req_i=0: release, lock_err_o=1 for one cycle, rr_ptr <= owner+1;
  - (c) clear_i.
- Timeout counter:
  - increments each Locked cycle with owner req_i=0;
  - resets on owner req_i=1;
  - saturates and is not used while Unlocked.
- Reads (wen=1) and writes below CfgBase other than the trigger never change lock state.
- Trigger write while Unlocked is a normal single transaction; no lock.
- Responses:
  - r_valid_o[head]=slv_r_valid_i when the FIFO is non-empty; pop on slv_r_valid_i.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - slv_r_valid_i with an empty FIFO is dropped; all r_valid_o stay 0.
  - r_data_o = slv_r_data_i always.
- Reset mid-lock or with responses outstanding discards all state; late slave responses are dropped per the empty-FIFO rule.

Test Plan:
- Both masters request single reads at add 'h0 every cycle, slv_gnt_i=1 -> grants alternate M0, M1, M0, ...; r_valid_o routed to the matching master in order.
- M0 writes 'h40..'h54 (6 beats) then trigger 'h0 while M1 requests continuously -> M1 gnt_o=0 throughout; locked_o=1 from the cycle after the 'h40 grant until the cycle after the trigger grant; M1 granted next.
- M1 locks with a write to 'h44, then drops req for 64 cycles -> lock_err_o pulses once at the 64th idle cycle; locked_o=0 next cycle; M0 pending request granted.
- Hold slv_r_valid_i=0 with MaxOutst=2 -> after 2 grants slv_req_o=0; one response -> exactly one further grant is possible.
- Assert rst_i mid-lock with 1 outstanding -> all outputs 0 asynchronously; a subsequent stray slv_r_valid_i produces no r_valid_o.
- clear_i during Locked -> locked_o=0 next cycle, rr_ptr=0, FIFO empty.
